// File: rtl/if_id_decode_buffer.sv
// ============================================================================
// if_id_decode_buffer
//
// IF/ID boundary register with instruction pre-decode. Fetched 16-bit words
// and their PC are registered and presented to Decode split into fields.
// A word with bit IMM_FLAG_BIT set is the first half of a two-word
// instruction. The next accepted word is its 16-bit immediate, and both are
// issued together as one instruction.
//
// Optional build macro:
//   IF_ID_PERF_CNT_EN  adds saturating perf_issued / perf_bubbles counters.
//
// Ports:
//   clk           in   clock, all state updates on posedge
//   reset         in   asynchronous active-high reset
//   in_valid      in   instruction / in_pc carry a fetched word
//   instruction   in   fetched 16-bit word
//   in_pc         in   PC of the fetched word
//   stall         in   Decode cannot accept, hold everything
//   flush         in   branch taken, drop buffered and incoming words
//   fetch_hold    out  registered copy of stall, tells Fetch to hold its PC
//   id_valid      out  id_* describe a valid issued instruction
//   id_inst       out  first (opcode) word
//   id_imm        out  immediate word, 0 when id_has_imm = 0
//   id_has_imm    out  issued instruction is two words long
//   id_pc         out  PC of the first word
//   id_opcode     out  id_inst[15:11]
//   id_rd         out  id_inst[10:8]
//   id_rs         out  id_inst[7:5]
//   id_rt         out  id_inst[4:2]
//   perf_issued   out  (IF_ID_PERF_CNT_EN) issued instruction count
//   perf_bubbles  out  (IF_ID_PERF_CNT_EN) non-stalled idle cycle count
//
// State table:
//   state   | meaning
//   S_FIRST | expecting a first (opcode) word
//   S_IMM   | first word of a two-word instruction held, expecting immediate
// ============================================================================
module if_id_decode_buffer #(
    parameter int IMM_FLAG_BIT = 15,
    parameter int PC_W         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [15:0]     instruction,
    input  logic [PC_W-1:0] in_pc,
    input  logic            stall,
    input  logic            flush,
    output logic            fetch_hold,
    output logic            id_valid,
    output logic [15:0]     id_inst,
    output logic [15:0]     id_imm,
    output logic            id_has_imm,
    output logic [PC_W-1:0] id_pc,
    output logic [4:0]      id_opcode,
    output logic [2:0]      id_rd,
    output logic [2:0]      id_rs,
    output logic [2:0]      id_rt
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [15:0]     perf_issued,
    output logic [15:0]     perf_bubbles
`endif
);

    typedef enum logic {
        S_FIRST = 1'b0,
        S_IMM   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            accept;

    logic [15:0]     hold_inst;
    logic [PC_W-1:0] hold_pc;

    logic            id_valid_nxt;
    logic [15:0]     id_inst_nxt;
    logic [15:0]     id_imm_nxt;
    logic            id_has_imm_nxt;
    logic [PC_W-1:0] id_pc_nxt;
    logic [15:0]     hold_inst_nxt;
    logic [PC_W-1:0] hold_pc_nxt;
    logic            issue;

    assign accept = in_valid & ~stall & ~flush;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Flush wins over everything; stall leaves the
    // state alone because accept is already low.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_FIRST;
        end else if (accept) begin
            case (state)
                S_FIRST: begin
                    if (instruction[IMM_FLAG_BIT]) begin
                        state_nxt = S_IMM;
                    end
                end
                S_IMM:   state_nxt = S_FIRST;
                default: state_nxt = S_FIRST;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: computes the values the issue and hold registers
    // take on the next edge.
    // Non-stalled cycles that do not issue drop id_valid and clear the
    // immediate fields, so id_imm is always 0 while id_has_imm is 0.
    // id_inst / id_pc keep their last value on such bubble cycles.
    // ------------------------------------------------------------------
    always_comb begin
        id_valid_nxt   = id_valid;
        id_inst_nxt    = id_inst;
        id_imm_nxt     = id_imm;
        id_has_imm_nxt = id_has_imm;
        id_pc_nxt      = id_pc;
        hold_inst_nxt  = hold_inst;
        hold_pc_nxt    = hold_pc;
        issue          = 1'b0;

        if (flush) begin
            id_valid_nxt   = 1'b0;
            id_has_imm_nxt = 1'b0;
            id_imm_nxt     = 16'h0000;
            hold_inst_nxt  = 16'h0000;
            hold_pc_nxt    = '0;
        end else if (!stall) begin
            id_valid_nxt   = 1'b0;
            id_has_imm_nxt = 1'b0;
            id_imm_nxt     = 16'h0000;
            if (accept) begin
                case (state)
                    S_FIRST: begin
                        if (instruction[IMM_FLAG_BIT]) begin
                            hold_inst_nxt = instruction;
                            hold_pc_nxt   = in_pc;
                        end else begin
                            issue        = 1'b1;
                            id_valid_nxt = 1'b1;
                            id_inst_nxt  = instruction;
                            id_pc_nxt    = in_pc;
                        end
                    end
                    S_IMM: begin
                        // The immediate's own flag bit carries no meaning.
                        issue          = 1'b1;
                        id_valid_nxt   = 1'b1;
                        id_inst_nxt    = hold_inst;
                        id_pc_nxt      = hold_pc;
                        id_imm_nxt     = instruction;
                        id_has_imm_nxt = 1'b1;
                    end
                    default: begin
                        id_valid_nxt = 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue, hold and fetch_hold registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid   <= 1'b0;
            id_inst    <= 16'h0000;
            id_imm     <= 16'h0000;
            id_has_imm <= 1'b0;
            id_pc      <= '0;
            hold_inst  <= 16'h0000;
            hold_pc    <= '0;
            fetch_hold <= 1'b0;
        end else begin
            id_valid   <= id_valid_nxt;
            id_inst    <= id_inst_nxt;
            id_imm     <= id_imm_nxt;
            id_has_imm <= id_has_imm_nxt;
            id_pc      <= id_pc_nxt;
            hold_inst  <= hold_inst_nxt;
            hold_pc    <= hold_pc_nxt;
            fetch_hold <= stall;
        end
    end

    // Field split always follows the registered word, valid or not.
    assign id_opcode = id_inst[15:11];
    assign id_rd     = id_inst[10:8];
    assign id_rs     = id_inst[7:5];
    assign id_rt     = id_inst[4:2];

`ifdef IF_ID_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters, frozen while stalled.
    // perf_issued counts on the edge that loads a new issue.
    // perf_bubbles counts non-stalled cycles where id_valid is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issued  <= 16'h0000;
            perf_bubbles <= 16'h0000;
        end else if (!stall) begin
            if (issue && (perf_issued != 16'hFFFF)) begin
                perf_issued <= perf_issued + 16'd1;
            end
            if (!id_valid && (perf_bubbles != 16'hFFFF)) begin
                perf_bubbles <= perf_bubbles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_decode_buffer.sv
module tb_if_id_decode_buffer;

    localparam int PC_W = 32;
    localparam int NVEC = 20;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [15:0]     instruction;
    logic [PC_W-1:0] in_pc;
    logic            stall;
    logic            flush;
    logic            fetch_hold;
    logic            id_valid;
    logic [15:0]     id_inst;
    logic [15:0]     id_imm;
    logic            id_has_imm;
    logic [PC_W-1:0] id_pc;
    logic [4:0]      id_opcode;
    logic [2:0]      id_rd;
    logic [2:0]      id_rs;
    logic [2:0]      id_rt;

    int n_total;
    int n_pass;

    if_id_decode_buffer #(
        .IMM_FLAG_BIT(15),
        .PC_W        (PC_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .instruction(instruction),
        .in_pc      (in_pc),
        .stall      (stall),
        .flush      (flush),
        .fetch_hold (fetch_hold),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_imm     (id_imm),
        .id_has_imm (id_has_imm),
        .id_pc      (id_pc),
        .id_opcode  (id_opcode),
        .id_rd      (id_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] ins;
        logic [31:0] pc;
        logic        st;
        logic        fl;
        logic        e_valid;
        logic        chk_data;   // compare id_inst/id_pc/id_imm/fields too
        logic [15:0] e_inst;
        logic [15:0] e_imm;
        logic        e_has;
        logic [31:0] e_pc;
        logic        e_hold;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(logic v, logic [15:0] ins, logic [31:0] pc,
                                logic st, logic fl, logic e_valid, logic chk_data,
                                logic [15:0] e_inst, logic [15:0] e_imm,
                                logic e_has, logic [31:0] e_pc, logic e_hold);
        vec_t r;
        r.v = v; r.ins = ins; r.pc = pc; r.st = st; r.fl = fl;
        r.e_valid = e_valid; r.chk_data = chk_data; r.e_inst = e_inst;
        r.e_imm = e_imm; r.e_has = e_has; r.e_pc = e_pc; r.e_hold = e_hold;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".id_valid"},   {31'd0, id_valid},   32'd0);
        chk({tag, ".id_inst"},    {16'd0, id_inst},    32'd0);
        chk({tag, ".id_imm"},     {16'd0, id_imm},     32'd0);
        chk({tag, ".id_has_imm"}, {31'd0, id_has_imm}, 32'd0);
        chk({tag, ".id_pc"},      id_pc,               32'd0);
        chk({tag, ".fetch_hold"}, {31'd0, fetch_hold}, 32'd0);
        chk({tag, ".fields"},     {21'd0, id_opcode, id_rd, id_rs, id_rt}, 32'd0);
    endtask

    initial begin
        logic [15:0] ei;
        n_total = 0;
        n_pass  = 0;

        //              v  ins       pc    st fl  eV dat e_inst    e_imm     has e_pc  hold
        // plain words back to back
        vecs[0]  = mk(1, 16'h0A12, 50,  0, 0,  1, 1, 16'h0A12, 16'h0000, 0, 50, 0);
        vecs[1]  = mk(1, 16'h1B40, 51,  0, 0,  1, 1, 16'h1B40, 16'h0000, 0, 51, 0);
        vecs[2]  = mk(1, 16'h2C84, 52,  0, 0,  1, 1, 16'h2C84, 16'h0000, 0, 52, 0);
        // two-word: bubble then assembled issue
        vecs[3]  = mk(1, 16'h8900, 60,  0, 0,  0, 0, 16'h0000, 16'h0000, 0, 0,  0);
        vecs[4]  = mk(1, 16'hBEEF, 61,  0, 0,  1, 1, 16'h8900, 16'hBEEF, 1, 60, 0);
        vecs[5]  = mk(0, 16'h0000, 0,   0, 0,  0, 0, 16'h0000, 16'h0000, 0, 0,  0);
        // stall freezes the issued word for three cycles
        vecs[6]  = mk(1, 16'h0A12, 70,  0, 0,  1, 1, 16'h0A12, 16'h0000, 0, 70, 0);
        vecs[7]  = mk(1, 16'h1B40, 71,  1, 0,  1, 1, 16'h0A12, 16'h0000, 0, 70, 1);
        vecs[8]  = mk(1, 16'h1B40, 71,  1, 0,  1, 1, 16'h0A12, 16'h0000, 0, 70, 1);
        vecs[9]  = mk(1, 16'h1B40, 71,  1, 0,  1, 1, 16'h0A12, 16'h0000, 0, 70, 1);
        vecs[10] = mk(1, 16'h1B40, 71,  0, 0,  1, 1, 16'h1B40, 16'h0000, 0, 71, 0);
        // flush while waiting for the immediate
        vecs[11] = mk(1, 16'h8900, 80,  0, 0,  0, 0, 16'h0000, 16'h0000, 0, 0,  0);
        vecs[12] = mk(1, 16'hBEEF, 81,  0, 1,  0, 0, 16'h0000, 16'h0000, 0, 0,  0);
        vecs[13] = mk(1, 16'h0A12, 82,  0, 0,  1, 1, 16'h0A12, 16'h0000, 0, 82, 0);
        // S_IMM survives an idle cycle and a stall
        vecs[14] = mk(1, 16'h8900, 90,  0, 0,  0, 0, 16'h0000, 16'h0000, 0, 0,  0);
        vecs[15] = mk(0, 16'h0000, 0,   0, 0,  0, 0, 16'h0000, 16'h0000, 0, 0,  0);
        vecs[16] = mk(1, 16'h1234, 91,  1, 0,  0, 0, 16'h0000, 16'h0000, 0, 0,  1);
        vecs[17] = mk(1, 16'hBEEF, 92,  0, 0,  1, 1, 16'h8900, 16'hBEEF, 1, 90, 0);
        // flush beats stall and drops the incoming plain word
        vecs[18] = mk(1, 16'h1B40, 93,  1, 1,  0, 0, 16'h0000, 16'h0000, 0, 0,  1);
        vecs[19] = mk(1, 16'h2C84, 94,  0, 0,  1, 1, 16'h2C84, 16'h0000, 0, 94, 0);

        reset = 1'b1; in_valid = 1'b0; instruction = 16'h0; in_pc = '0;
        stall = 1'b0; flush = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            in_valid = vecs[i].v; instruction = vecs[i].ins; in_pc = vecs[i].pc;
            stall = vecs[i].st; flush = vecs[i].fl;
            @(posedge clk); #1;
            chk($sformatf("v%0d.id_valid", i),   {31'd0, id_valid},   {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d.id_has_imm", i), {31'd0, id_has_imm}, {31'd0, vecs[i].e_has});
            chk($sformatf("v%0d.fetch_hold", i), {31'd0, fetch_hold}, {31'd0, vecs[i].e_hold});
            if (vecs[i].chk_data) begin
                ei = vecs[i].e_inst;
                chk($sformatf("v%0d.id_inst", i), {16'd0, id_inst}, {16'd0, ei});
                chk($sformatf("v%0d.id_imm", i),  {16'd0, id_imm},  {16'd0, vecs[i].e_imm});
                chk($sformatf("v%0d.id_pc", i),   id_pc,            vecs[i].e_pc);
                chk($sformatf("v%0d.fields", i),
                    {21'd0, id_opcode, id_rd, id_rs, id_rt},
                    {21'd0, ei[15:11], ei[10:8], ei[7:5], ei[4:2]});
            end
            if (i == 0) begin
                chk("v0.opcode", {27'd0, id_opcode}, 32'd1);
                chk("v0.rd",     {29'd0, id_rd},     32'd2);
                chk("v0.rs",     {29'd0, id_rs},     32'd0);
                chk("v0.rt",     {29'd0, id_rt},     32'd4);
            end
        end

        // Async reset mid-cycle while in S_IMM
        in_valid = 1'b1; instruction = 16'h8900; in_pc = 100; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        chk("ar.bubble", {31'd0, id_valid}, 32'd0);
        in_valid = 1'b0;
        #3 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b1; instruction = 16'h0A12; in_pc = 110;
        @(posedge clk); #1;
        chk("ar.id_valid",   {31'd0, id_valid},   32'd1);
        chk("ar.id_inst",    {16'd0, id_inst},    32'h0A12);
        chk("ar.id_has_imm", {31'd0, id_has_imm}, 32'd0);
        chk("ar.id_imm",     {16'd0, id_imm},     32'd0);
        chk("ar.id_pc",      id_pc,               32'd110);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("ar.one_cycle", {31'd0, id_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
